// File: rtl/temperature_accept_gate.sv
// temperature_accept_gate: accept/reject stage for received temperature words, with warm-up,
// settle hold-off after each accept, consecutive-reject alarm and saturating statistics.
module temperature_accept_gate #(
    parameter int WIDTH           = 16,
    parameter int WARMUP_COUNT    = 16,
    parameter int SETTLE_CYCLES   = 3,
    parameter int ALARM_THRESHOLD = 4,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_valid,
    input  logic [WIDTH-1:0]       sample,
    input  logic [WIDTH-1:0]       upper_bound,
    input  logic [WIDTH-1:0]       lower_bound,
    output logic                   accept_temperature,
    output logic [WIDTH-1:0]       accepted_sample,
    output logic                   temperature_ready,
    output logic [WIDTH-1:0]       temperature,
    output logic                   reject_pulse,
    output logic                   anomaly_alarm,
    output logic                   warmup_done,
    output logic                   sample_dropped,
    output logic [COUNT_WIDTH-1:0] accepted_count,
    output logic [COUNT_WIDTH-1:0] rejected_count
);
    localparam int WW = $clog2(WARMUP_COUNT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 2);
    localparam int AW = $clog2(ALARM_THRESHOLD + 1);

    typedef enum logic [1:0] {WARMUP, READY, SETTLE} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       hold_q, hold_d, temp_q, temp_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [WW-1:0]          warm_q, warm_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic [AW-1:0]          consec_q, consec_d;
    logic [COUNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d, rej_cnt_q, rej_cnt_d;
    logic                   accept_q, reject_q, drop_q, alarm_q, alarm_d, done_q, done_d;
    logic                   decide, in_range, accept, reject;
    state_t                 resume;

    always_comb begin
        decide       = hold_valid_q && state_q != SETTLE;
        in_range     = lower_bound <= hold_q && hold_q <= upper_bound;
        accept       = decide && (state_q == WARMUP || in_range);
        reject       = decide && state_q == READY && !in_range;
        hold_d       = sample_valid ? sample : hold_q;
        hold_valid_d = sample_valid || (hold_valid_q && !decide);
        warm_d       = (accept && warm_q != WW'(WARMUP_COUNT)) ? warm_q + 1'b1 : warm_q;
        done_d       = done_q || warm_d == WW'(WARMUP_COUNT);
        resume       = (warm_d == WW'(WARMUP_COUNT)) ? READY : WARMUP;
        temp_d       = accept ? hold_q : temp_q;
        acc_cnt_d    = (accept && acc_cnt_q != '1) ? acc_cnt_q + 1'b1 : acc_cnt_q;
        rej_cnt_d    = (reject && rej_cnt_q != '1) ? rej_cnt_q + 1'b1 : rej_cnt_q;
        consec_d     = accept ? '0 : (reject && consec_q != AW'(ALARM_THRESHOLD)) ? consec_q + 1'b1 : consec_q;
        alarm_d      = accept ? 1'b0 : (alarm_q || consec_d == AW'(ALARM_THRESHOLD));
        state_d      = state_q;
        settle_d     = settle_q;
        if (accept) begin
            state_d  = (SETTLE_CYCLES == 0) ? resume : SETTLE;
            settle_d = SW'(SETTLE_CYCLES);
        end else if (state_q == SETTLE) begin
            settle_d = settle_q - 1'b1;
            state_d  = (settle_q <= SW'(1)) ? resume : SETTLE;
        end
    end

    // Pending sample discarded on reset: hold_valid clears with everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= WARMUP;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            temp_q       <= '0;
            warm_q       <= '0;
            settle_q     <= '0;
            consec_q     <= '0;
            acc_cnt_q    <= '0;
            rej_cnt_q    <= '0;
            accept_q     <= 1'b0;
            reject_q     <= 1'b0;
            drop_q       <= 1'b0;
            alarm_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            temp_q       <= temp_d;
            warm_q       <= warm_d;
            settle_q     <= settle_d;
            consec_q     <= consec_d;
            acc_cnt_q    <= acc_cnt_d;
            rej_cnt_q    <= rej_cnt_d;
            accept_q     <= accept;
            reject_q     <= reject;
            drop_q       <= sample_valid && hold_valid_q && !decide;
            alarm_q      <= alarm_d;
            done_q       <= done_d;
        end
    end

    assign accept_temperature = accept_q;
    assign temperature_ready  = accept_q;
    assign accepted_sample    = temp_q;
    assign temperature        = temp_q;
    assign reject_pulse       = reject_q;
    assign anomaly_alarm      = alarm_q;
    assign warmup_done        = done_q;
    assign sample_dropped     = drop_q;
    assign accepted_count     = acc_cnt_q;
    assign rejected_count     = rej_cnt_q;
endmodule

// File: doc/temperature_accept_gate.md
Name: temperature_accept_gate

Overview:
- Acceptance/output stage directly downstream of the averaging and bounds stage of the temperature anomaly pipeline.
- Takes each fully received serial temperature word and decides whether to accept it:
  - During warm-up, every sample is accepted unconditionally.
  - After warm-up, a sample is accepted only if it lies inside [lower_bound, upper_bound].
- Drives the history shifter's accept strobe and the module-level temperature outputs, and counts rejected readings (anomalies).
- Holds off decisions while the history/average/bounds pipeline settles after each accept.

Parameters:
- WIDTH, 16, bit width of temperature samples and bounds.
- WARMUP_COUNT, 16, number of unconditional accepts needed to fill the history.
- SETTLE_CYCLES, 3, cycles to wait after an accept before the next decision (shift, average, bound registers).
- ALARM_THRESHOLD, 4, consecutive rejects that raise anomaly_alarm.
- COUNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe: a new word is on sample (temperature-received done).
- sample  in  WIDTH  received temperature word.
- upper_bound  in  WIDTH  current inclusive upper acceptance bound.
- lower_bound  in  WIDTH  current inclusive lower acceptance bound.
- accept_temperature  out  1  one-cycle strobe to the history shifter; the rising edge shifts sample into history.
- accepted_sample  out  WIDTH  word presented to the history shifter; valid while accept_temperature is high.
- temperature_ready  out  1  one-cycle strobe, coincident with a temperature update.
- temperature  out  WIDTH  last accepted temperature; held between accepts.
- reject_pulse  out  1  one-cycle strobe on each rejected sample.
- anomaly_alarm  out  1  level signal: ALARM_THRESHOLD or more consecutive rejects.
- warmup_done  out  1  level signal: WARMUP_COUNT accepts completed.
- sample_dropped  out  1  one-cycle strobe when a pending sample is overwritten.
- accepted_count  out  COUNT_WIDTH  saturating count of accepts.
- rejected_count  out  COUNT_WIDTH  saturating count of rejects.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0, including temperature, the counters, warmup_done and anomaly_alarm.
  - The hold register is emptied, the warm-up and consecutive-reject counters clear, and the state returns to WARMUP.
  - Reset asserted mid-settle or with a sample pending discards that sample.
- Capture:
  - When sample_valid is high, sample is registered into the 1-deep hold register and hold_valid is set.
  - If hold_valid is already set and the hold is not consumed in that cycle, the new sample overwrites the pending one and sample_dropped pulses.
  - If sample_valid coincides with a decision cycle, the old hold is decided, the new sample is captured, and no drop is flagged.
- States: WARMUP, READY, SETTLE.
  - WARMUP or READY with hold_valid is a decision cycle. Outputs register at the end of that cycle and hold_valid clears.
  - Latency: sample_valid in cycle N, with the state not SETTLE in cycle N+1, gives strobes high in cycle N+2.
  - Bounds are sampled in the decision cycle only.
- Accept condition:
  - In WARMUP: always.
  - In READY: lower_bound <= hold <= upper_bound, unsigned and inclusive at both ends.
  - If lower_bound > upper_bound, every READY sample is rejected.
- On accept:
  - accept_temperature and temperature_ready pulse for 1 cycle.
  - accepted_sample and temperature load the hold value.
  - accepted_count increments; the consecutive-reject counter clears; anomaly_alarm clears.
  - The state goes to SETTLE with a counter loaded to SETTLE_CYCLES.
- SETTLE:
  - Decrements each cycle. Samples are still captured but not decided.
  - At 0, goes to READY if the warm-up accept count equals WARMUP_COUNT, otherwise back to WARMUP.
  - warmup_done rises in the cycle the WARMUP_COUNT-th accept registers and stays high until reset.
  - With SETTLE_CYCLES = 0, the state returns directly to WARMUP/READY the cycle after the accept.
- On reject (READY only):
  - reject_pulse fires; rejected_count increments.
  - The consecutive counter increments, saturating at ALARM_THRESHOLD.
  - anomaly_alarm sets when the counter reaches ALARM_THRESHOLD.
  - No SETTLE; temperature is unchanged.
- Counters saturate at all-ones and do not wrap.
- accept_temperature and reject_pulse are never high in the same cycle.

Test Plan:
- Reset then 16 samples of 100 spaced 40 cycles apart → 16 accept_temperature pulses, warmup_done high after the 16th, accepted_count = 16, state READY.
- Post-warmup with bounds 90/110: samples 90, 110, 111, 89 → accept, accept, reject, reject; temperature = 110; rejected_count = 2; boundary values accepted.
- 4 consecutive out-of-range samples (200) → anomaly_alarm rises on the 4th reject_pulse; a following in-range sample 100 → accept, alarm clears.
- Back-to-back sample_valid at cycles N and N+1 right after an accept (in SETTLE) → first sample overwritten, sample_dropped pulses once, only the second is decided, after SETTLE ends.
- sample_valid at cycle N in READY → accept_temperature high in exactly cycle N+2; sample_valid coincident with a decision cycle → both samples decided, no drop.
- Reset asserted during SETTLE with a sample pending → all outputs 0 immediately (asynchronous); after release, the next sample 500 is accepted unconditionally (WARMUP).
